flash_cmd_model: RTL and testbench

- Clocked, parametrised successor to the board's NOR flash simulation model, used in testbenches in place of the external parallel flash.
- Decodes the standard command set: read array, read status, clear status, word program, block erase.
- Models flash physics (program clears bits only; erase sets to all-ones), busy timing, write protect, reset/power-down and STS.
- Sits on the NF_* pins of the flash controller under test.

---
 rtl/flash_pkg.sv | 34 +++
 rtl/flash_bus_sync.sv | 78 +++++++
 rtl/flash_cmd_model.sv | 233 +++++++++++++++++++++++
 tb/tb_flash_cmd_model.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the clocked NOR flash command model:
// command codes, status-register bit positions and the command FSM states.
package flash_pkg;

    localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
    localparam logic [7:0] CMD_READ_STATUS = 8'h70;
    localparam logic [7:0] CMD_CLR_STATUS  = 8'h50;
    localparam logic [7:0] CMD_PROG        = 8'h40;
    localparam logic [7:0] CMD_PROG_ALT    = 8'h10;
    localparam logic [7:0] CMD_ERASE       = 8'h20;
    localparam logic [7:0] CMD_CONFIRM     = 8'hD0;

    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;
    localparam int SR_PROT_ERR  = 1;

    localparam logic [7:0] SR_RESET = 8'h80;

    typedef enum logic [2:0] {
        ST_READ_ARRAY  = 3'd0,
        ST_READ_STATUS = 3'd1,
        ST_PROG_SETUP  = 3'd2,
        ST_PROG_BUSY   = 3'd3,
        ST_ERASE_SETUP = 3'd4,
        ST_ERASE_WALK  = 3'd5,
        ST_ERASE_BUSY  = 3'd6
    } flash_state_e;

    function automatic logic is_erasing(input flash_state_e st);
        return (st == ST_ERASE_WALK) || (st == ST_ERASE_BUSY);
    endfunction

endpackage

// File: rtl/flash_bus_sync.sv
// Samples the asynchronous NF_* pins into the clk domain and turns a sampled
// rising edge of WE (with CE low) into a one-cycle write strobe.
module flash_bus_sync
    import flash_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d,
    input  logic              ce,
    input  logic              oe,
    input  logic              we,
    input  logic              rp,
    input  logic              wp,
    input  logic              byte_sel,
    output logic              rp_smp,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_wp
);

    logic [ADDR_W-1:0] a_r;
    logic [DATA_W-1:0] d_r;
    logic              ce_r;
    logic              we_r;
    logic              rp_r;
    logic              wp_r;
    logic [1:0]        smp_unused_r;

    logic [ADDR_W-1:0] a_p_r;
    logic [DATA_W-1:0] d_p_r;
    logic              ce_p_r;
    logic              we_p_r;
    logic              wp_p_r;

    // Pin sample stage plus the one-deep history used by the WE edge detector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r          <= '0;
            d_r          <= '0;
            ce_r         <= 1'b1;
            we_r         <= 1'b1;
            rp_r         <= 1'b1;
            wp_r         <= 1'b1;
            smp_unused_r <= 2'b11;
            a_p_r        <= '0;
            d_p_r        <= '0;
            ce_p_r       <= 1'b1;
            we_p_r       <= 1'b1;
            wp_p_r       <= 1'b1;
        end else begin
            a_r          <= a;
            d_r          <= d;
            ce_r         <= ce;
            we_r         <= we;
            rp_r         <= rp;
            wp_r         <= wp;
            smp_unused_r <= {oe, byte_sel};
            a_p_r        <= a_r;
            d_p_r        <= d_r;
            ce_p_r       <= ce_r;
            we_p_r       <= we_r;
            wp_p_r       <= wp_r;
        end
    end

    // Address/data/WP come from the sample taken while WE was still low.
    assign wr_stb  = !we_p_r && we_r && !ce_p_r;
    assign wr_addr = a_p_r;
    assign wr_data = d_p_r;
    assign wr_wp   = wp_p_r;
    assign rp_smp  = rp_r;

endmodule

// File: rtl/flash_cmd_model.sv
// Clocked NOR flash model: command FSM, storage array with program/erase
// physics, busy timing, block-0 write protect and reset/power-down abort.
module flash_cmd_model
    import flash_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                BLK_W     = 4,
    parameter int                PROG_CYC  = 16,
    parameter int                ERASE_CYC = 64,
    parameter logic [DATA_W-1:0] INIT_VAL  = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] NF_A,
    inout  wire  [DATA_W-1:0] NF_D,
    input  logic              NF_CE,
    input  logic              NF_OE,
    input  logic              NF_WE,
    input  logic              NF_RP,
    input  logic              NF_WP,
    input  logic              NF_BYTE,
    output logic              NF_STS
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int CNT_MAX = (PROG_CYC > ERASE_CYC) ? PROG_CYC : ERASE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    logic              rp_smp;
    logic              wr_stb;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_wp;
    logic              wr_blk0_s;
    logic              wr_locked_s;

    flash_state_e      state_r, state_s;
    logic [7:0]        sr_r, sr_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] data_r, data_s;
    logic [BLK_W-1:0]  off_r, off_s;
    logic              sts_r, sts_s;

    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_wa_s;
    logic [DATA_W-1:0] mem_wd_s;
    logic [DATA_W-1:0] mem_r [DEPTH] = '{default: INIT_VAL};

    logic              drive_s;
    logic [DATA_W-1:0] dout_s;

    flash_bus_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (NF_A),
        .d        (NF_D),
        .ce       (NF_CE),
        .oe       (NF_OE),
        .we       (NF_WE),
        .rp       (NF_RP),
        .wp       (NF_WP),
        .byte_sel (NF_BYTE),
        .rp_smp   (rp_smp),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_wp    (wr_wp)
    );

    assign wr_blk0_s   = (wr_addr[ADDR_W-1:BLK_W] == '0);
    assign wr_locked_s = wr_blk0_s && !wr_wp;

    // Next-state, status and storage-write decode for the command FSM.
    always_comb begin
        state_s  = state_r;
        sr_s     = sr_r;
        cnt_s    = cnt_r;
        addr_s   = addr_r;
        data_s   = data_r;
        off_s    = off_r;
        sts_s    = sts_r;
        mem_we_s = 1'b0;
        mem_wa_s = addr_r;
        mem_wd_s = data_r;
        if (!rp_smp) begin
            state_s = ST_READ_ARRAY;
            sr_s    = SR_RESET;
            sr_s[SR_ERASE_ERR] = is_erasing(state_r);
            sts_s   = 1'b1;
            cnt_s   = '0;
            off_s   = '0;
        end else begin
            case (state_r)
                ST_READ_ARRAY, ST_READ_STATUS: begin
                    if (wr_stb) begin
                        case (wr_data[7:0])
                            CMD_READ_ARRAY:  state_s = ST_READ_ARRAY;
                            CMD_READ_STATUS: state_s = ST_READ_STATUS;
                            CMD_CLR_STATUS: begin
                                sr_s[SR_ERASE_ERR] = 1'b0;
                                sr_s[SR_PROG_ERR]  = 1'b0;
                                sr_s[SR_PROT_ERR]  = 1'b0;
                            end
                            CMD_PROG, CMD_PROG_ALT: state_s = ST_PROG_SETUP;
                            CMD_ERASE:       state_s = ST_ERASE_SETUP;
                            default:         state_s = state_r;
                        endcase
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_PROG_SETUP: begin
                    if (wr_stb) begin
                        addr_s = wr_addr;
                        data_s = wr_data;
                        if (wr_locked_s) begin
                            sr_s[SR_PROG_ERR] = 1'b1;
                            sr_s[SR_PROT_ERR] = 1'b1;
                            state_s = ST_READ_STATUS;
                        end else begin
                            sr_s[SR_READY] = 1'b0;
                            sts_s   = 1'b0;
                            cnt_s   = CNT_W'(PROG_CYC);
                            state_s = ST_PROG_BUSY;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_PROG_BUSY: begin
                    // Completion on the final count keeps STS low for exactly PROG_CYC cycles.
                    if (cnt_r <= CNT_W'(1)) begin
                        mem_we_s = 1'b1;
                        mem_wa_s = addr_r;
                        mem_wd_s = mem_r[addr_r] & data_r;
                        sr_s[SR_READY] = 1'b1;
                        sts_s   = 1'b1;
                        cnt_s   = '0;
                        state_s = ST_READ_STATUS;
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                ST_ERASE_SETUP: begin
                    if (wr_stb) begin
                        if (wr_data[7:0] != CMD_CONFIRM) begin
                            sr_s[SR_ERASE_ERR] = 1'b1;
                            sr_s[SR_PROG_ERR]  = 1'b1;
                            state_s = ST_READ_STATUS;
                        end else if (wr_locked_s) begin
                            sr_s[SR_ERASE_ERR] = 1'b1;
                            sr_s[SR_PROT_ERR]  = 1'b1;
                            state_s = ST_READ_STATUS;
                        end else begin
                            addr_s  = {wr_addr[ADDR_W-1:BLK_W], BLK_W'(0)};
                            off_s   = '0;
                            sr_s[SR_READY] = 1'b0;
                            sts_s   = 1'b0;
                            state_s = ST_ERASE_WALK;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_ERASE_WALK: begin
                    mem_we_s = 1'b1;
                    mem_wa_s = {addr_r[ADDR_W-1:BLK_W], off_r};
                    mem_wd_s = '1;
                    if (off_r == '1) begin
                        cnt_s   = CNT_W'(ERASE_CYC);
                        state_s = ST_ERASE_BUSY;
                    end else begin
                        off_s = off_r + BLK_W'(1);
                    end
                end
                ST_ERASE_BUSY: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        sr_s[SR_READY] = 1'b1;
                        sts_s   = 1'b1;
                        cnt_s   = '0;
                        state_s = ST_READ_STATUS;
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_s = ST_READ_ARRAY;
                    sr_s    = SR_RESET;
                    sts_s   = 1'b1;
                end
            endcase
        end
    end

    // FSM, status and busy-timer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_READ_ARRAY;
            sr_r    <= SR_RESET;
            cnt_r   <= '0;
            addr_r  <= '0;
            data_r  <= '0;
            off_r   <= '0;
            sts_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            sr_r    <= sr_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            off_r   <= off_s;
            sts_r   <= sts_s;
        end
    end

    // Storage array; deliberately untouched by rst_n so contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    assign drive_s = !NF_CE && !NF_OE && NF_WE && NF_RP;
    assign dout_s  = (state_r == ST_READ_ARRAY) ? mem_r[NF_A] : DATA_W'(sr_r);
    assign NF_D    = drive_s ? dout_s : {DATA_W{1'bz}};
    assign NF_STS  = sts_r;

endmodule

// File: tb/tb_flash_cmd_model.sv
// Directed plus randomized bench for flash_cmd_model, checked against a
// word-array reference model of the flash command rules.
module tb_flash_cmd_model;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int BW = 4;
    localparam int PC = 16;
    localparam int EC = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] nf_a;
    logic          nf_ce, nf_oe, nf_we, nf_rp, nf_wp, nf_byte;
    logic          nf_sts;
    logic [DW-1:0] tb_d;
    logic          tb_drv;
    wire  [DW-1:0] nf_d;

    int            tests_run = 0;
    int            tests_failed = 0;
    logic [DW-1:0] ref_mem [256];

    assign nf_d = tb_drv ? tb_d : {DW{1'bz}};

    always #5 clk = ~clk;

    flash_cmd_model #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BLK_W     (BW),
        .PROG_CYC  (PC),
        .ERASE_CYC (EC),
        .INIT_VAL  ({DW{1'b1}})
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .NF_A    (nf_a),
        .NF_D    (nf_d),
        .NF_CE   (nf_ce),
        .NF_OE   (nf_oe),
        .NF_WE   (nf_we),
        .NF_RP   (nf_rp),
        .NF_WP   (nf_wp),
        .NF_BYTE (nf_byte),
        .NF_STS  (nf_sts)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] addr, input logic [7:0] data);
        nf_a = addr; tb_d = DW'(data); tb_drv = 1'b1;
        nf_oe = 1'b1; nf_ce = 1'b0; nf_we = 1'b0;
        @(negedge clk); @(negedge clk);
        nf_we = 1'b1;
        @(negedge clk);
        tb_drv = 1'b0; nf_ce = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [AW-1:0] addr, output logic [DW-1:0] val);
        nf_a = addr; tb_drv = 1'b0; nf_we = 1'b1; nf_ce = 1'b0; nf_oe = 1'b0;
        #2;
        val = nf_d;
        nf_ce = 1'b1; nf_oe = 1'b1;
        @(negedge clk);
    endtask

    // Number of sampled cycles with STS low; bounded so a stuck DUT cannot hang the run.
    task automatic busy_len(output int n);
        int guard;
        guard = 0;
        n = 0;
        while (nf_sts === 1'b1 && guard < 8) begin
            @(negedge clk); guard++;
        end
        while (nf_sts === 1'b0 && n < 2000) begin
            n++; @(negedge clk);
        end
    endtask

    task automatic status_check(input logic [7:0] exp, input string tag);
        logic [DW-1:0] v;
        bus_write(8'h00, 8'h70);
        bus_read(8'h00, v);
        check(tag, v, exp);
    endtask

    task automatic read_check(input logic [AW-1:0] addr, input string tag);
        logic [DW-1:0] v;
        bus_read(addr, v);
        check(tag, v, ref_mem[addr]);
    endtask

    task automatic do_program(input logic [AW-1:0] addr, input logic [7:0] data, input string tag);
        int n;
        bus_write(addr, 8'h40);
        bus_write(addr, data);
        busy_len(n);
        check({tag, "_busy"}, n, PC);
        ref_mem[addr] = ref_mem[addr] & data;
        status_check(8'h80, {tag, "_sr"});
        bus_write(8'h00, 8'hFF);
    endtask

    task automatic do_erase(input logic [AW-1:0] addr, input string tag);
        int n;
        bus_write(addr, 8'h20);
        bus_write(addr, 8'hD0);
        busy_len(n);
        check({tag, "_busy"}, n, (1 << BW) + EC);
        for (int i = 0; i < (1 << BW); i++) ref_mem[{addr[7:4], 4'h0} + i] = 8'hFF;
        status_check(8'h80, {tag, "_sr"});
        bus_write(8'h00, 8'hFF);
    endtask

    initial begin
        logic [DW-1:0] v;
        logic [AW-1:0] ra;
        logic [7:0]    rd;
        int            op;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'hFF;
        rst_n = 1'b0; nf_a = '0; nf_ce = 1'b1; nf_oe = 1'b1; nf_we = 1'b1;
        nf_rp = 1'b1; nf_wp = 1'b1; nf_byte = 1'b1; tb_d = '0; tb_drv = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_sts", nf_sts, 1'b1);
        read_check(8'h13, "rst_read13");
        status_check(8'h80, "rst_sr");
        bus_write(8'h00, 8'hFF);

        // Program then program again: bits can only clear
        do_program(8'h13, 8'hA5, "prog1");
        read_check(8'h13, "prog1_read");
        do_program(8'h13, 8'h5A, "prog2");
        read_check(8'h13, "prog2_and");

        // Block erase around 0x17; neighbours of the block must survive
        do_program(8'h0F, 8'h3C, "pre0f");
        do_program(8'h20, 8'hC3, "pre20");
        do_program(8'h18, 8'h00, "pre18");
        do_erase(8'h17, "erase1");
        for (int i = 8'h10; i <= 8'h1F; i++) read_check(AW'(i), "erase1_word");
        read_check(8'h0F, "erase1_below");
        read_check(8'h20, "erase1_above");

        // Erase sequence error, then clear status
        bus_write(8'h30, 8'h20);
        bus_write(8'h30, 8'h33);
        bus_read(8'h00, v);
        check("seq_err_sr", v, 8'hB0);
        bus_write(8'h00, 8'h50);
        bus_read(8'h00, v);
        check("clr_sr", v, 8'h80);
        bus_write(8'h00, 8'hFF);

        // Write protect on block 0 only
        nf_wp = 1'b0;
        bus_write(8'h05, 8'h40);
        bus_write(8'h05, 8'h3C);
        check("wp_sts", nf_sts, 1'b1);
        bus_read(8'h00, v);
        check("wp_prog_sr", v, 8'h92);
        bus_write(8'h00, 8'h50);
        bus_write(8'h05, 8'h20);
        bus_write(8'h05, 8'hD0);
        bus_read(8'h00, v);
        check("wp_erase_sr", v, 8'hA2);
        bus_write(8'h00, 8'h50);
        bus_write(8'h00, 8'hFF);
        read_check(8'h05, "wp_unchanged");
        do_program(8'h10, 8'h77, "wp_blk1");
        read_check(8'h10, "wp_blk1_read");
        nf_wp = 1'b1;
        do_program(8'h05, 8'h3C, "wp_off");
        read_check(8'h05, "wp_off_read");

        // Abort a program mid-busy with RP
        bus_write(8'h30, 8'h40);
        bus_write(8'h30, 8'h0F);
        repeat (3) @(negedge clk);
        nf_rp = 1'b0;
        @(negedge clk);
        nf_rp = 1'b1;
        @(negedge clk);
        check("abort_sts", nf_sts, 1'b1);
        read_check(8'h30, "abort_prog_read");
        status_check(8'h80, "abort_prog_sr");
        bus_write(8'h00, 8'hFF);

        // Abort an erase after exactly one walked word
        do_program(8'h4F, 8'h00, "pre4f");
        do_program(8'h40, 8'h00, "pre40");
        bus_write(8'h4F, 8'h20);
        bus_write(8'h4F, 8'hD0);
        nf_rp = 1'b0;
        @(negedge clk);
        nf_rp = 1'b1;
        @(negedge clk);
        check("abort_erase_sts", nf_sts, 1'b1);
        ref_mem[8'h40] = 8'hFF;
        read_check(8'h40, "abort_erase_walked");
        read_check(8'h4F, "abort_erase_kept");
        status_check(8'hA0, "abort_erase_sr");
        bus_write(8'h00, 8'h50);
        bus_write(8'h00, 8'hFF);

        // Randomized programs, erases and reads against the reference array
        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 7));
            ra = AW'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 255));
            if (op < 3) begin
                do_program(ra, rd, "rand_prog");
            end else if (op < 7) begin
                read_check(ra, "rand_read");
            end else begin
                do_erase(ra, "rand_erase");
            end
        end
        for (int i = 0; i < 16; i++) read_check(AW'($urandom_range(0, 255)), "final_read");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
